sw_step_cond: RTL
=================

Name: sw_step_cond

Overview:
- Input-conditioning stage directly upstream of the CPU top.
- Synchronises and debounces the 16 board switches and a single-step button.
- Emits per-bit edge pulses, plus a registered CPU clock-enable pulse `cpu_ce`.
- `cpu_ce` replaces the raw `clkdiv`-bit CPU clock: the core runs on `clk` gated by `cpu_ce`, in free-run (fast/slow) or single-step mode.

Parameters:
- WIDTH, 16: number of switch channels.
- TICK_DIV, 100000: `clk` cycles per debounce sample tick.
- DB_TICKS, 10: consecutive mismatching ticks required to accept a new level.
- FAST_LOG2, 25: free-run fast period is 2^FAST_LOG2 cycles.
- SLOW_LOG2, 27: free-run slow period is 2^SLOW_LOG2 cycles (must be ≥ FAST_LOG2).
- RATE_SW, 15: `sw_o` bit selecting slow rate (1 = slow).
- STEP_SW, 1: `sw_o` bit selecting step mode (1 = step).

Ports:
- clk  in  1  system clock
- rstn  in  1  reset, asynchronous, active-low
- sw_raw  in  WIDTH  raw board switches (asynchronous)
- btn_step_raw  in  1  raw step push-button (asynchronous, active-high)
- sw_o  out  WIDTH  debounced switch levels (drives core `sw_i`)
- sw_rise  out  WIDTH  one-cycle pulse when a `sw_o` bit goes 0→1
- sw_fall  out  WIDTH  one-cycle pulse when a `sw_o` bit goes 1→0
- step_mode  out  1  equals `sw_o[STEP_SW]`
- cpu_ce  out  1  one-cycle CPU advance enable, registered
- ce_cnt  out  32  count of `cpu_ce` pulses since reset

Behaviour:
- **Reset.** Clock: one clock `clk`. Reset: `rstn` is asynchronous, active-low. While `rstn`=0, all flops clear and all outputs are 0: synchronisers, tick counter, debounce counters, `sw_o`, edge pulses, rate counter, `cpu_ce`, `ce_cnt`.
- **Synchroniser.** Two flops per channel (WIDTH + 1 for the button). The synchronised value is visible 2 cycles after a raw change.
- **Tick prescaler.** Counter runs 0..TICK_DIV-1 and wraps. `tick` is high for the one cycle where count == TICK_DIV-1.
- **Debounce, per channel (including the button).**
  - If the synchronised value == current debounced level, clear the channel counter on every cycle, regardless of tick.
  - Otherwise, increment the counter on `tick`.
  - On the tick where the counter would reach DB_TICKS: the debounced level takes the synchronised value and the counter clears.
  - Latency after the synchronised value changes: (DB_TICKS-1)*TICK_DIV+1 .. DB_TICKS*TICK_DIV cycles. Add 2 cycles for the synchroniser.
  - Any return to the old level restarts the count (glitch rejection).
- **Edge pulses.** `sw_rise[i]`/`sw_fall[i]` are registered and high in exactly the first cycle `sw_o[i]` shows the new value. They are never high in any other cycle.
- **Step pulse (internal).** One-cycle pulse on the debounced button's 0→1 edge. Holding the button yields one pulse; the release produces none.
- **Rate counter.** Free-running, SLOW_LOG2 bits wide, wraps. It is never cleared except by reset.
  - `rate_hit` = low FAST_LOG2 bits all ones when `sw_o[RATE_SW]`=0.
  - `rate_hit` = all SLOW_LOG2 bits ones when `sw_o[RATE_SW]`=1.
- **cpu_ce (registered).**
  - Free-run mode (`sw_o[STEP_SW]`=0): `cpu_ce` <= `rate_hit`.
  - Step mode (`sw_o[STEP_SW]`=1): `cpu_ce` <= step pulse. Rate hits are ignored.
  - Step presses in free-run mode are discarded, not queued.
  - A step pulse coinciding with a mode change is judged by the mode value in that same cycle.
  - A rate or mode change takes effect on the next cycle. The counter phase is preserved, so the first `rate_hit` after a change occurs at the next natural alignment.
- **ce_cnt.** Increments by 1 in the cycle after each `cpu_ce`=1, with 32-bit wrap (0xFFFFFFFF → 0).
- **Reset mid-operation.** Partially counted debounce is lost. After `rstn` rises, a switch already held at 1 reappears on `sw_o` after the full debounce latency and produces a `sw_rise` pulse.

Test Plan:
All scenarios use TICK_DIV=4, DB_TICKS=3, FAST_LOG2=3, SLOW_LOG2=5.
1. **Clean edge.** `sw_raw[3]` 0→1 at cycle 0 → `sw_o[3]`=1 first seen in cycle 11..14. `sw_rise[3]` is high exactly that one cycle. No `sw_fall`; other bits unchanged.
2. **Glitch.** `sw_raw[7]` high for 6 cycles, then low → `sw_o[7]` stays 0 and no rise/fall pulse occurs over 100 cycles. Then hold high 40 cycles → `sw_o[7]`=1.
3. **Free-run rates.** All switches 0 → `cpu_ce` single-cycle pulses exactly every 8 cycles, and `ce_cnt`=10 after the 10th pulse. Set `sw[15]`=1 → after debounce, pulse spacing is exactly 32 cycles.
4. **Single-step.** Set `sw[1]`=1; after debounce there is no `cpu_ce` for 200 cycles. Press the button for 50 cycles with 2-cycle bounces at its start → exactly one `cpu_ce`. Release and press again → second pulse; `ce_cnt` advances by exactly 2.
5. **Step press in free-run.** `sw[1]`=0, press button → `cpu_ce` pulses remain strictly periodic every 8 cycles, with no extra pulse.
6. **Async reset.** Drive `rstn`=0 mid-debounce of `sw[5]` with `sw_raw[5]` held at 1 → all outputs 0 immediately, with no clock edge required. After release, `sw_o[5]` returns to 1 within 11..14 cycles, accompanied by a `sw_rise[5]` pulse. `ce_cnt` restarts from 0.

Source files
------------

// File: rtl/sw_step_cond_if.sv
// Switch/button conditioning bus: raw board inputs in, conditioned levels,
// edge pulses and the CPU clock-enable out. master = conditioner, slave = consumer.
interface sw_step_cond_if #(
    parameter int WIDTH = 16
);
    logic [WIDTH-1:0] sw_raw;
    logic             btn_step_raw;
    logic [WIDTH-1:0] sw_o;
    logic [WIDTH-1:0] sw_rise;
    logic [WIDTH-1:0] sw_fall;
    logic             step_mode;
    logic             cpu_ce;
    logic [31:0]      ce_cnt;

    modport master (
        input  sw_raw, btn_step_raw,
        output sw_o, sw_rise, sw_fall, step_mode, cpu_ce, ce_cnt
    );

    modport slave (
        output sw_raw, btn_step_raw,
        input  sw_o, sw_rise, sw_fall, step_mode, cpu_ce, ce_cnt
    );
endinterface

// File: rtl/sw_step_cond.sv
// Input conditioning ahead of the CPU: synchronise + debounce switches and step
// button, emit edge pulses and a registered CPU clock-enable (free-run or step).
// Ports: clk, rstn (async, active-low); bus (master): sw_raw, btn_step_raw in;
//        sw_o, sw_rise, sw_fall, step_mode, cpu_ce, ce_cnt out.
module sw_step_cond #(
    parameter int WIDTH     = 16,
    parameter int TICK_DIV  = 100000,
    parameter int DB_TICKS  = 10,
    parameter int FAST_LOG2 = 25,
    parameter int SLOW_LOG2 = 27,
    parameter int RATE_SW   = 15,
    parameter int STEP_SW   = 1
) (
    input  logic            clk,
    input  logic            rstn,
    sw_step_cond_if.master  bus
);
    // Channel WIDTH is the step button; channels below it are the switches.
    localparam int CH = WIDTH + 1;
    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int DW = $clog2(DB_TICKS + 1);

    logic [CH-1:0]          sync1, sync2;
    logic [CH-1:0]          db, db_nxt;
    logic [CH-1:0][DW-1:0]  dcnt, dcnt_nxt;
    logic [TW-1:0]          tcnt;
    logic                   tick;
    logic [WIDTH-1:0]       rise, fall;
    logic                   step_pls;
    logic [SLOW_LOG2-1:0]   rcnt;
    logic                   rate_hit;
    logic                   ce;
    logic [31:0]            ccnt;

    assign tick = (tcnt == TW'(TICK_DIV - 1));

    // A channel only accumulates while it disagrees with its debounced level;
    // any agreement, even between ticks, throws away the partial count.
    always_comb begin
        db_nxt   = db;
        dcnt_nxt = dcnt;
        for (int c = 0; c < CH; c++) begin
            if (sync2[c] == db[c]) begin
                dcnt_nxt[c] = '0;
            end else if (tick) begin
                if (dcnt[c] == DW'(DB_TICKS - 1)) begin
                    db_nxt[c]   = sync2[c];
                    dcnt_nxt[c] = '0;
                end else begin
                    dcnt_nxt[c] = dcnt[c] + DW'(1);
                end
            end
        end
    end

    // Phase of the rate counter is kept across rate changes, so the slow
    // rate lands on a fast-rate boundary.
    assign rate_hit = db[RATE_SW] ? (&rcnt) : (&rcnt[FAST_LOG2-1:0]);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync1    <= '0;
            sync2    <= '0;
            db       <= '0;
            dcnt     <= '0;
            tcnt     <= '0;
            rise     <= '0;
            fall     <= '0;
            step_pls <= 1'b0;
            rcnt     <= '0;
            ce       <= 1'b0;
            ccnt     <= '0;
        end else begin
            sync1    <= {bus.btn_step_raw, bus.sw_raw};
            sync2    <= sync1;
            db       <= db_nxt;
            dcnt     <= dcnt_nxt;
            tcnt     <= tick ? '0 : tcnt + TW'(1);
            rise     <= db_nxt[WIDTH-1:0] & ~db[WIDTH-1:0];
            fall     <= ~db_nxt[WIDTH-1:0] & db[WIDTH-1:0];
            step_pls <= db_nxt[WIDTH] & ~db[WIDTH];
            rcnt     <= rcnt + SLOW_LOG2'(1);
            // Step presses in free-run are dropped here, never queued.
            ce       <= db[STEP_SW] ? step_pls : rate_hit;
            ccnt     <= ccnt + 32'(ce);
        end
    end

    assign bus.sw_o      = db[WIDTH-1:0];
    assign bus.sw_rise   = rise;
    assign bus.sw_fall   = fall;
    assign bus.step_mode = db[STEP_SW];
    assign bus.cpu_ce    = ce;
    assign bus.ce_cnt    = ccnt;
endmodule
